// File: rtl/inv_park_module.sv
// Inverse Park transform (d/q -> alpha/beta) for the current loop. One shared
// signed multiplier is time-multiplexed over four product states.
module inv_park_module #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                         sys_clk,
  input  logic                         reset,
  input  logic                         system_initilization_done_in,
  input  logic                         inv_park_enable_in,
  input  logic signed [DATA_WIDTH-1:0] Ud_in,
  input  logic signed [DATA_WIDTH-1:0] Uq_in,
  input  logic signed [DATA_WIDTH-1:0] sin_theta_in,
  input  logic signed [DATA_WIDTH-1:0] cos_theta_in,
  output logic signed [DATA_WIDTH-1:0] U_alpha_out,
  output logic signed [DATA_WIDTH-1:0] U_beta_out,
  output logic                         svpwm_cal_enable_out,
  output logic                         busy_out
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + 1;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MUL0 = 3'd1;
  localparam logic [2:0] MUL1 = 3'd2;
  localparam logic [2:0] MUL2 = 3'd3;
  localparam logic [2:0] MUL3 = 3'd4;
  localparam logic [2:0] SUM  = 3'd5;
  localparam logic [2:0] OUT  = 3'd6;

  // Symmetric clamp: the most negative code is never produced.
  localparam logic signed [SW-1:0] SAT_POS = {{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_NEG = -SAT_POS;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] ud;
    logic signed [DATA_WIDTH-1:0] uq;
    logic signed [DATA_WIDTH-1:0] sin_t;
    logic signed [DATA_WIDTH-1:0] cos_t;
  } operands_t;

  logic [2:0]                   state;
  operands_t                    hold;
  logic signed [DATA_WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0]         mul_a_ext, mul_b_ext, product;
  logic signed [PW-1:0]         p_ud_cos, p_uq_sin, p_ud_sin, p_uq_cos;
  logic signed [SW-1:0]         sum_alpha, sum_beta;
  logic signed [DATA_WIDTH-1:0] alpha_sat, beta_sat;

  function automatic logic signed [DATA_WIDTH-1:0] scale_sat(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> (DATA_WIDTH - 1);
    if (sh > SAT_POS)      scale_sat = SAT_POS[DATA_WIDTH-1:0];
    else if (sh < SAT_NEG) scale_sat = SAT_NEG[DATA_WIDTH-1:0];
    else                   scale_sat = sh[DATA_WIDTH-1:0];
  endfunction

  // Operand steering for the shared multiplier.
  always_comb begin
    mul_a = hold.ud;
    mul_b = hold.cos_t;
    case (state)
      MUL1: begin mul_a = hold.uq; mul_b = hold.sin_t; end
      MUL2: begin mul_a = hold.ud; mul_b = hold.sin_t; end
      MUL3: begin mul_a = hold.uq; mul_b = hold.cos_t; end
      default: ;
    endcase
  end

  assign mul_a_ext = PW'(mul_a);
  assign mul_b_ext = PW'(mul_b);
  assign product   = mul_a_ext * mul_b_ext;

  assign alpha_sat = scale_sat(sum_alpha);
  assign beta_sat  = scale_sat(sum_beta);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state                <= IDLE;
      hold                 <= '0;
      p_ud_cos             <= '0;
      p_uq_sin             <= '0;
      p_ud_sin             <= '0;
      p_uq_cos             <= '0;
      sum_alpha            <= '0;
      sum_beta             <= '0;
      U_alpha_out          <= '0;
      U_beta_out           <= '0;
      svpwm_cal_enable_out <= 1'b0;
      busy_out             <= 1'b0;
    end else begin
      svpwm_cal_enable_out <= 1'b0;
      // Losing system init aborts silently; outputs keep the last result.
      if (state != IDLE && !system_initilization_done_in) begin
        state    <= IDLE;
        busy_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (inv_park_enable_in && system_initilization_done_in) begin
              hold     <= '{ud: Ud_in, uq: Uq_in, sin_t: sin_theta_in, cos_t: cos_theta_in};
              state    <= MUL0;
              busy_out <= 1'b1;
            end
          end
          MUL0: begin p_ud_cos <= product; state <= MUL1; end
          MUL1: begin p_uq_sin <= product; state <= MUL2; end
          MUL2: begin p_ud_sin <= product; state <= MUL3; end
          MUL3: begin p_uq_cos <= product; state <= SUM;  end
          SUM: begin
            sum_alpha <= SW'(p_ud_cos) - SW'(p_uq_sin);
            sum_beta  <= SW'(p_ud_sin) + SW'(p_uq_cos);
            state     <= OUT;
          end
          OUT: begin
            U_alpha_out          <= alpha_sat;
            U_beta_out           <= beta_sat;
            svpwm_cal_enable_out <= 1'b1;
            busy_out             <= 1'b0;
            state                <= IDLE;
          end
          default: begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inv_park_module.sv
// Bench for inv_park_module: cycle-level reference model compared every cycle,
// plus directed vectors with hand-computed results.
module tb_inv_park_module;
  localparam int DW = 16;

  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic done = 1'b0;
  logic en = 1'b0;
  logic signed [DW-1:0] ud = '0, uq = '0, sn = '0, cs = '0;
  logic signed [DW-1:0] ua, ub;
  logic pulse, busy;

  int checks = 0;
  int errors = 0;
  int n_pulse = 0;

  always #5 sys_clk = ~sys_clk;

  inv_park_module #(.DATA_WIDTH(DW)) dut (
    .sys_clk                      (sys_clk),
    .reset                        (reset),
    .system_initilization_done_in (done),
    .inv_park_enable_in           (en),
    .Ud_in                        (ud),
    .Uq_in                        (uq),
    .sin_theta_in                 (sn),
    .cos_theta_in                 (cs),
    .U_alpha_out                  (ua),
    .U_beta_out                   (ub),
    .svpwm_cal_enable_out         (pulse),
    .busy_out                     (busy)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Floor division by 2^15 then clamp to +/-32767.
  function automatic longint scale(input longint s);
    longint t;
    t = s >>> 15;
    if (t > 32767) t = 32767;
    if (t < -32767) t = -32767;
    return t;
  endfunction

  // Reference model: a transform is a countdown of 6 edges after capture.
  int m_cnt = 0;
  longint m_ud = 0, m_uq = 0, m_s = 0, m_c = 0;
  longint exp_a = 0, exp_b = 0;
  bit exp_p = 1'b0;
  bit started = 1'b0;

  always @(posedge sys_clk) begin
    started <= 1'b1;
    if (reset) begin
      m_cnt <= 0; exp_a <= 0; exp_b <= 0; exp_p <= 1'b0;
    end else begin
      exp_p <= 1'b0;
      if (m_cnt != 0) begin
        if (!done) m_cnt <= 0;
        else if (m_cnt == 1) begin
          exp_a <= scale(m_ud * m_c - m_uq * m_s);
          exp_b <= scale(m_ud * m_s + m_uq * m_c);
          exp_p <= 1'b1;
          m_cnt <= 0;
        end else m_cnt <= m_cnt - 1;
      end else if (en && done) begin
        m_ud <= longint'(ud); m_uq <= longint'(uq);
        m_s  <= longint'(sn); m_c  <= longint'(cs);
        m_cnt <= 6;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (started) begin
      chk("alpha", longint'(ua), exp_a);
      chk("beta", longint'(ub), exp_b);
      chk("pulse", longint'(pulse), longint'(exp_p));
      chk("busy", longint'(busy), longint'(m_cnt != 0));
      if (pulse) n_pulse++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic start(input int a, input int b, input int s, input int c);
    ud = DW'(a); uq = DW'(b); sn = DW'(s); cs = DW'(c);
    en = 1'b1;
    cyc(1);
    en = 1'b0;
  endtask

  task automatic wait_pulse(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge sys_clk);
      if (pulse) begin lat = i; break; end
    end
  endtask

  task automatic run_vec(input string nm, input int a, input int b, input int s, input int c,
                         input int ea, input int eb);
    int lat, p0;
    p0 = n_pulse;
    start(a, b, s, c);
    wait_pulse(lat);
    chk({nm, "_latency"}, lat, 6);
    chk({nm, "_alpha"}, longint'(ua), ea);
    chk({nm, "_beta"}, longint'(ub), eb);
    cyc(2);
    chk({nm, "_npulse"}, n_pulse - p0, 1);
  endtask

  initial begin
    int p0, lat;
    logic signed [DW-1:0] keep_a, keep_b;
    cyc(3);
    chk("reset_alpha", longint'(ua), 0);
    chk("reset_beta", longint'(ub), 0);
    chk("reset_busy", longint'(busy), 0);
    reset = 1'b0;
    done = 1'b1;
    cyc(2);

    run_vec("v1", 16384, 0, 0, 32767, 16383, 0);
    run_vec("v2", 0, 16384, 32767, 0, -16384, 0);
    run_vec("v3", 32767, 32767, 23170, 23170, 0, 32767);
    run_vec("v4", -32767, 32767, 23170, 23170, -32767, 0);

    // Enable held high: back-to-back transforms, busy drops only on pulses.
    p0 = n_pulse;
    ud = 1000; uq = -2000; sn = 12000; cs = -30000;
    en = 1'b1;
    cyc(20);
    en = 1'b0;
    cyc(10);
    chk("held_npulse", n_pulse - p0, 3);

    // Second enable while busy is ignored.
    p0 = n_pulse;
    start(5000, 7000, -9000, 11000);
    cyc(1);
    en = 1'b1; ud = 30000;
    cyc(1);
    en = 1'b0;
    cyc(10);
    chk("busy_ignore_npulse", n_pulse - p0, 1);

    // Enable without system init.
    p0 = n_pulse;
    done = 1'b0;
    start(100, 200, 300, 400);
    chk("noinit_busy", longint'(busy), 0);
    cyc(8);
    chk("noinit_npulse", n_pulse - p0, 0);
    done = 1'b1;
    cyc(1);

    // Init dropped while in MUL2.
    p0 = n_pulse;
    keep_a = ua; keep_b = ub;
    start(-20000, 15000, 3000, -4000);
    cyc(2);
    done = 1'b0;
    cyc(1);
    chk("drop_busy", longint'(busy), 0);
    cyc(8);
    chk("drop_npulse", n_pulse - p0, 0);
    chk("drop_alpha_hold", longint'(ua), longint'(keep_a));
    chk("drop_beta_hold", longint'(ub), longint'(keep_b));
    done = 1'b1;
    cyc(1);

    // Reset while in SUM.
    p0 = n_pulse;
    start(16384, 0, 0, 32767);
    cyc(4);
    reset = 1'b1;
    cyc(1);
    chk("rst_alpha", longint'(ua), 0);
    chk("rst_beta", longint'(ub), 0);
    chk("rst_busy", longint'(busy), 0);
    reset = 1'b0;
    cyc(8);
    chk("rst_npulse", n_pulse - p0, 0);
    run_vec("post_rst", 0, 16384, 32767, 0, -16384, 0);

    // Random traffic including extremes and init glitches.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        ud = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
        uq = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
        sn = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
        cs = ($urandom_range(0, 1) != 0) ? 16'sh7fff : 16'sh8000;
      end else begin
        ud = DW'($urandom); uq = DW'($urandom);
        sn = DW'($urandom); cs = DW'($urandom);
      end
      en   = ($urandom_range(0, 2) == 0);
      done = ($urandom_range(0, 29) != 0);
      cyc(1);
    end
    en = 1'b0;
    done = 1'b1;
    p0 = n_pulse;
    start(-1, 1, 32767, -32768);
    wait_pulse(lat);
    chk("final_latency", lat, 6);
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
